// File: rtl/enviar_datos_pkg.sv
// -----------------------------------------------------------------------------
// enviar_datos_pkg
// Shared definitions for the enviar_datos_n serial transmitter:
//   - state_t and the FSM state encodings (legacy-compatible localparams)
//   - default parameter values
//   - width helpers for the baud counter and the bit counter
// Optional feature macro: ENVIAR_DATOS_PARITY_EN (adds the PARITY state).
// -----------------------------------------------------------------------------
package enviar_datos_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_START  = 3'd1;
   localparam state_t ST_DATA   = 3'd2;
`ifdef ENVIAR_DATOS_PARITY_EN
   localparam state_t ST_PARITY = 3'd3;
`endif
   localparam state_t ST_STOP   = 3'd4;

   localparam int DEF_DATA_W     = 8;
   localparam int DEF_CLK_DIV    = 5208;
   localparam int DEF_STOP_BITS  = 1;
   localparam int DEF_FIFO_DEPTH = 4;

   // Baud counter runs 0..clk_div-1.
   function automatic int baud_w(input int clk_div);
      return $clog2(clk_div);
   endfunction

   // Bit counter must be able to hold data_w.
   function automatic int bit_w(input int data_w);
      return $clog2(data_w + 1);
   endfunction

endpackage

// File: rtl/enviar_datos_fifo.sv
// -----------------------------------------------------------------------------
// enviar_datos_fifo
// Transmit buffer: power-of-two circular FIFO with a separate occupancy count
// so full and empty are unambiguous. Head word is visible on dout whenever
// the FIFO is non-empty (show-ahead).
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   push, din       write strobe and data; a push while full is dropped unless
//                   a pop happens on the same edge
//   pop, dout       read strobe and head data
//   lleno, vacio    full / empty flags
//   count           number of stored words (0..FIFO_DEPTH)
// -----------------------------------------------------------------------------
module enviar_datos_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic                          pop,
   input  logic [DATA_W-1:0]             din,
   output logic [DATA_W-1:0]             dout,
   output logic                          lleno,
   output logic                          vacio,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              wr_en;
   logic              rd_en;

   assign lleno = (count == CNT_W'(FIFO_DEPTH));
   assign vacio = (count == '0);

   // A pop on the same edge frees the slot, so a full FIFO still accepts it.
   assign wr_en = push && (!lleno || pop);
   assign rd_en = pop && !vacio;

   assign dout = mem[rd_ptr];

   // NOTE: storage has no reset; the count register alone decides which
   // entries are valid, and leaving the array unreset lets it map to RAM.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // Depth is a power of two, so the pointers wrap by overflow.
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/enviar_datos_n.sv
// -----------------------------------------------------------------------------
// enviar_datos_n
// Buffered asynchronous serial transmitter: start bit (0), DATA_W payload bits
// LSB first, optional even parity bit, STOP_BITS stop bits (1). Frames queued
// in the FIFO go out back-to-back with no idle gap.
// Optional feature macro: ENVIAR_DATOS_PARITY_EN (even parity bit between
// DATA and STOP; absent from the default build).
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous active-low reset
//   start    one-cycle write strobe for datos
//   datos    payload, DATA_W bits
//   tx       serial line, idle high
//   comm_in  one-cycle pulse when a frame's last stop bit ends
//   bussy_e  high while a frame is in flight or the FIFO holds data
//   lleno    FIFO full
// -----------------------------------------------------------------------------
module enviar_datos_n
   import enviar_datos_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int CLK_DIV    = DEF_CLK_DIV,
   parameter int STOP_BITS  = DEF_STOP_BITS,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] datos,
   output logic              tx,
   output logic              comm_in,
   output logic              bussy_e,
   output logic              lleno
);

   localparam int BAUD_W = baud_w(CLK_DIV);
   localparam int BIT_W  = bit_w(DATA_W);
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

   state_t              state;
   logic [BAUD_W-1:0]   baud_cnt;
   logic [BIT_W-1:0]    bit_cnt;
   logic [DATA_W-1:0]   shreg;

   logic [DATA_W-1:0]   fifo_dout;
   logic                fifo_vacio;
   logic [CNT_W-1:0]    fifo_count;
   logic                pop;

   logic                baud_last;
   logic                data_last;
   logic                stop_last;

`ifdef ENVIAR_DATOS_PARITY_EN
   logic                par_bit;
`endif

   enviar_datos_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (start),
      .pop   (pop),
      .din   (datos),
      .dout  (fifo_dout),
      .lleno (lleno),
      .vacio (fifo_vacio),
      .count (fifo_count)
   );

   assign baud_last = (baud_cnt == BAUD_W'(CLK_DIV - 1));
   assign data_last = (bit_cnt  == BIT_W'(DATA_W - 1));
   assign stop_last = (bit_cnt  == BIT_W'(STOP_BITS - 1));

   // Pop from IDLE, or at the very end of STOP so the next start bit follows
   // the last stop bit with no idle cycle.
   assign pop = !fifo_vacio &&
                ((state == ST_IDLE) ||
                 ((state == ST_STOP) && baud_last && stop_last));

   assign bussy_e = (state != ST_IDLE) || (fifo_count != '0);

   // Line is decoded from registers only; reset forces state to IDLE, which
   // returns the line high immediately without waiting for a clock.
   // NOTE: tx gets a default before the case so no path leaves it unassigned
   // (otherwise a latch would be inferred).
   always_comb begin
      tx = 1'b1;
      case (state)
         ST_START:  tx = 1'b0;
         ST_DATA:   tx = shreg[0];
`ifdef ENVIAR_DATOS_PARITY_EN
         ST_PARITY: tx = par_bit;
`endif
         default:   tx = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         comm_in  <= 1'b0;
`ifdef ENVIAR_DATOS_PARITY_EN
         par_bit  <= 1'b0;
`endif
      end else begin
         comm_in <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (!fifo_vacio) begin
                  state    <= ST_START;
                  baud_cnt <= '0;
               end
            end

            ST_START: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  state    <= ST_DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            ST_DATA: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  shreg    <= {1'b0, shreg[DATA_W-1:1]};
                  if (data_last) begin
                     bit_cnt <= '0;
`ifdef ENVIAR_DATOS_PARITY_EN
                     state   <= ST_PARITY;
`else
                     state   <= ST_STOP;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

`ifdef ENVIAR_DATOS_PARITY_EN
            ST_PARITY: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  state    <= ST_STOP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
`endif

            ST_STOP: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (stop_last) begin
                     bit_cnt <= '0;
                     comm_in <= 1'b1;
                     state   <= fifo_vacio ? ST_IDLE : ST_START;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            default: state <= ST_IDLE;
         endcase

         // Load the next payload on the same edge the FIFO head is consumed.
         if (pop) begin
            shreg   <= fifo_dout;
`ifdef ENVIAR_DATOS_PARITY_EN
            par_bit <= ^fifo_dout;
`endif
         end
      end
   end

endmodule

// File: tb/tb_enviar_datos_n.sv
// -----------------------------------------------------------------------------
// tb_enviar_datos_n
// Directed bench for enviar_datos_n with CLK_DIV=4, DATA_W=8. u_dut uses one
// stop bit; u_dut2 uses two stop bits. Honours ENVIAR_DATOS_PARITY_EN.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_enviar_datos_n;

   localparam int CLK_DIV = 4;
   localparam int DATA_W  = 8;
`ifdef ENVIAR_DATOS_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int FL  = (1 + DATA_W + P + 1) * CLK_DIV;   // frame, 1 stop bit
   localparam int FL2 = (1 + DATA_W + P + 2) * CLK_DIV;   // frame, 2 stop bits

   logic       clk    = 1'b0;
   logic       rst    = 1'b0;
   logic       start  = 1'b0;
   logic [7:0] datos  = '0;
   logic       start2 = 1'b0;
   logic [7:0] datos2 = '0;
   logic       tx, comm_in, bussy_e, lleno;
   logic       tx2, comm_in2, bussy2, lleno2;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] rx_q[$];

   always #5 clk = ~clk;

   enviar_datos_n #(
      .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .STOP_BITS(1), .FIFO_DEPTH(4)
   ) u_dut (
      .clk(clk), .rst(rst), .start(start), .datos(datos),
      .tx(tx), .comm_in(comm_in), .bussy_e(bussy_e), .lleno(lleno)
   );

   enviar_datos_n #(
      .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .STOP_BITS(2), .FIFO_DEPTH(4)
   ) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .datos(datos2),
      .tx(tx2), .comm_in(comm_in2), .bussy_e(bussy2), .lleno(lleno2)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_rx(input string tag, input logic [7:0] exp);
      if (rx_q.size() == 0) check(tag, 32'hFFFF_FFFF, {24'h0, exp});
      else                  check(tag, {24'h0, rx_q.pop_front()}, {24'h0, exp});
   endtask

   // Called at a falling edge `off` cycles after the first start bit of a run
   // of contiguous frames began; `done` frames of the run have already ended.
   // Expects n more comm_in pulses, each exactly on a frame boundary, with
   // bussy_e high in between.
   task automatic wait_frames(input string tag, input int n, input int off,
                              input int done);
      int seen      = 0;
      int bad_gap   = 0;
      int busy_low  = 0;
      for (int c = off + 1; c <= (done + n) * FL + 10 && seen < n; c++) begin
         @(negedge clk);
         if (comm_in) begin
            seen++;
            if (c != (done + seen) * FL) bad_gap++;
         end else if (!bussy_e) begin
            busy_low++;
         end
      end
      check({tag, "_pulses"}, seen, n);
      check({tag, "_timing"}, bad_gap, 0);
      check({tag, "_busy"}, busy_low, 0);
   endtask

   // Line decoder for u_dut: samples each bit in its middle.
   initial begin : monitor
      logic [7:0] got;
      forever begin
         @(negedge clk);
         if (rst && tx === 1'b0) begin
            repeat (2) @(negedge clk);
            check("mon_start_bit", tx, 1'b0);
            for (int i = 0; i < 8; i++) begin
               repeat (4) @(negedge clk);
               got[i] = tx;
            end
`ifdef ENVIAR_DATOS_PARITY_EN
            repeat (4) @(negedge clk);
            check("mon_parity_bit", tx, ^got);
`endif
            repeat (4) @(negedge clk);
            check("mon_stop_bit", tx, 1'b1);
            rx_q.push_back(got);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int extra;
      int stop_low;
      logic [7:0] got2;

      // ---- reset state ----
      @(negedge clk);
      check("rst_tx", tx, 1'b1);
      check("rst_comm_in", comm_in, 1'b0);
      check("rst_bussy_e", bussy_e, 1'b0);
      check("rst_lleno", lleno, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // ---- single byte A5 ----
      start = 1'b1; datos = 8'hA5;
      @(negedge clk);
      start = 1'b0;
      check("single_tx_not_yet", tx, 1'b1);
      check("single_busy_queued", bussy_e, 1'b1);
      @(negedge clk);
      check("single_tx_fall", tx, 1'b0);
      wait_frames("single", 1, 0, 0);
      check("single_busy_end", bussy_e, 1'b0);
      @(negedge clk);
      check("single_comm_one_cycle", comm_in, 1'b0);
      expect_rx("single_data", 8'hA5);
      repeat (5) @(negedge clk);

      // ---- burst of 4 ----
      start = 1'b1; datos = 8'h01;
      @(negedge clk); datos = 8'h02;
      @(negedge clk); datos = 8'h03;
      check("burst_tx_fall", tx, 1'b0);
      @(negedge clk); datos = 8'h04;
      @(negedge clk); start = 1'b0;
      wait_frames("burst", 4, 2, 0);
      for (int i = 1; i <= 4; i++) expect_rx("burst_data", 8'(i));
      repeat (5) @(negedge clk);

      // ---- overflow: 6 consecutive starts, 6th dropped ----
      start = 1'b1; datos = 8'h11;
      @(negedge clk); datos = 8'h12;
      @(negedge clk); datos = 8'h13;
      check("ovf_tx_fall", tx, 1'b0);
      @(negedge clk); datos = 8'h14;
      @(negedge clk); datos = 8'h15;
      @(negedge clk); datos = 8'h16;
      check("ovf_full", lleno, 1'b1);
      @(negedge clk); start = 1'b0;
      wait_frames("ovf", 5, 4, 0);
      extra = 0;
      repeat (FL + 8) begin
         @(negedge clk);
         if (comm_in || !tx) extra++;
      end
      check("ovf_no_6th", extra, 0);
      check("ovf_count", rx_q.size(), 5);
      for (int i = 0; i < 5; i++) expect_rx("ovf_data", 8'(8'h11 + i));
      check("ovf_empty_lleno", lleno, 1'b0);

      // ---- push on the pop edge while full ----
      start = 1'b1; datos = 8'h21;
      @(negedge clk); datos = 8'h22;
      @(negedge clk); datos = 8'h23;
      check("pp_tx_fall", tx, 1'b0);
      @(negedge clk); datos = 8'h24;
      @(negedge clk); datos = 8'h25;
      @(negedge clk); start = 1'b0;                  // offset 3
      check("pp_full", lleno, 1'b1);
      repeat (FL - 4) @(negedge clk);                // offset FL-1
      check("pp_full_before_pop", lleno, 1'b1);
      start = 1'b1; datos = 8'h26;
      @(negedge clk);                                // offset FL
      start = 1'b0;
      check("pp_pop_edge", comm_in, 1'b1);
      check("pp_still_full", lleno, 1'b1);
      wait_frames("pp", 5, FL, 1);
      for (int i = 0; i < 6; i++) expect_rx("pp_order", 8'(8'h21 + i));
      repeat (5) @(negedge clk);

      // ---- reset in the middle of DATA bit 3 ----
      start = 1'b1; datos = 8'hA5;
      @(negedge clk); datos = 8'h5B;
      @(negedge clk); start = 1'b0;
      check("rst_mid_tx_fall", tx, 1'b0);
      repeat (18) @(negedge clk);                    // middle of bit 3
      check("rst_mid_bit3", tx, 1'b0);
      rst = 1'b0;
      #1;
      check("rst_mid_tx_high", tx, 1'b1);
      check("rst_mid_comm", comm_in, 1'b0);
      check("rst_mid_busy", bussy_e, 1'b0);
      check("rst_mid_lleno", lleno, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      extra = 0;
      repeat (FL + 20) begin
         @(negedge clk);
         if (comm_in || !tx || bussy_e) extra++;
      end
      check("rst_mid_quiet", extra, 0);
      rx_q.delete();

      // ---- two stop bits, datos 07 ----
      start2 = 1'b1; datos2 = 8'h07;
      @(negedge clk); start2 = 1'b0;
      check("sb2_busy", bussy2, 1'b1);
      check("sb2_lleno", lleno2, 1'b0);
      @(negedge clk);
      check("sb2_tx_fall", tx2, 1'b0);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         repeat (4) @(negedge clk);
         got2[i] = tx2;
      end
      check("sb2_data", got2, 8'h07);
`ifdef ENVIAR_DATOS_PARITY_EN
      repeat (4) @(negedge clk);
      check("sb2_parity", tx2, 1'b1);
`endif
      repeat (2) @(negedge clk);                     // first stop cycle
      stop_low = 0;
      for (int k = 0; k < 8; k++) begin
         if (tx2 !== 1'b1 || comm_in2 !== 1'b0) stop_low++;
         @(negedge clk);
      end
      check("sb2_stop_8_cycles", stop_low, 0);
      check("sb2_comm", comm_in2, 1'b1);
      @(negedge clk);
      check("sb2_idle", bussy2, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
